// File: rtl/pu_array_if.sv
// Bus between the weight/activation buffers, the pu_array MAC row and the temp/y buffers.
// The master drives accumulate/snapshot controls and out_ready; the slave returns the drained lanes.
interface pu_array_if #(
  parameter int LANES = 64,
  parameter int XW    = 25,
  parameter int WW    = 18,
  parameter int OUTW  = 32,
  parameter int SHW   = 5,
  parameter int IDXW  = $clog2(LANES)
);
  logic                   acc_clear;
  logic                   acc_en;
  logic signed [XW-1:0]   x_in;
  logic [LANES*WW-1:0]    w_in;
  logic                   snap;
  logic [1:0]             mode;
  logic [SHW-1:0]         shift;
  logic                   busy;
  logic                   snap_err;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUTW-1:0]        out_data;
  logic [IDXW-1:0]        out_idx;
  logic                   out_last;

  modport master (
    output acc_clear, acc_en, x_in, w_in, snap, mode, shift, out_ready,
    input  busy, snap_err, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  acc_clear, acc_en, x_in, w_in, snap, mode, shift, out_ready,
    output busy, snap_err, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/pu_array.sv
// Row of signed MAC lanes sharing one activation; a shadow bank lets the next
// accumulation overlap a one-lane-per-handshake post-processed drain.
module pu_array #(
  parameter int LANES  = 64,
  parameter int XW     = 25,
  parameter int WW     = 18,
  parameter int ACCW   = 32,
  parameter int PSHIFT = 0,
  parameter int OUTW   = 32,
  parameter int SHW    = 5,
  parameter int IDXW   = $clog2(LANES)
) (
  input  logic        clk,
  input  logic        rst,
  pu_array_if.slave   bus
);
  localparam int PW = XW + WW;
  localparam int CW = ((ACCW > OUTW) ? ACCW : OUTW) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic signed [CW-1:0] OMAX = {{(CW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN = {{(CW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  logic signed [ACCW-1:0] prod_p0   [LANES];
  logic signed [ACCW-1:0] acc_p0    [LANES];
  logic signed [ACCW-1:0] shadow_p1 [LANES];

  logic [0:0]      state;
  logic [IDXW-1:0] ptr;
  logic [1:0]      mode_q;
  logic [SHW-1:0]  shift_q;
  logic            snap_err_q;
  logic            hs, at_last, accept, reject;

  // Saturating post-process; the compare runs one bit wider than either operand.
  function automatic logic [OUTW-1:0] post_proc(input logic signed [ACCW-1:0] v,
                                                input logic [1:0] m,
                                                input logic [SHW-1:0] s);
    logic signed [CW-1:0] w;
    w = CW'(v);
    if (!m[1]) begin
      if (!m[0]) w = w >>> s;
      if (w[CW-1] || (w == OMAX - OMAX)) w = OMAX - OMAX;
      else if (w > OMAX)                 w = OMAX;
    end else begin
      if (w > OMAX)      w = OMAX;
      else if (w < OMIN) w = OMIN;
    end
    return OUTW'(w);
  endfunction

  // Stage p0: full-width product, scaled, then fitted to the accumulator width
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PW-1:0] xe, we, full;
    assign xe         = PW'(bus.x_in);
    assign we         = PW'($signed(bus.w_in[WW*k +: WW]));
    assign full       = xe * we;
    assign prod_p0[k] = ACCW'(full >>> PSHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) acc_p0[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.acc_clear)   acc_p0[k] <= bus.acc_en ? prod_p0[k] : '0;
        else if (bus.acc_en) acc_p0[k] <= acc_p0[k] + prod_p0[k];
      end
    end
  end

  // Stage p1: shadow bank and drain control
  assign at_last = (ptr == IDXW'(LANES - 1));
  assign hs      = (state == DRAIN) && bus.out_ready;
  assign accept  = bus.snap && ((state == IDLE) || (hs && at_last));
  assign reject  = bus.snap && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      mode_q     <= '0;
      shift_q    <= '0;
      snap_err_q <= 1'b0;
      for (int k = 0; k < LANES; k++) shadow_p1[k] <= '0;
    end else begin
      snap_err_q <= reject;
      if (accept) begin
        state   <= DRAIN;
        ptr     <= '0;
        mode_q  <= bus.mode;
        shift_q <= bus.shift;
        for (int k = 0; k < LANES; k++) shadow_p1[k] <= acc_p0[k];
      end else if (hs) begin
        if (at_last) begin
          state <= IDLE;
          ptr   <= '0;
        end else begin
          ptr <= ptr + IDXW'(1);
        end
      end
    end
  end

  assign bus.busy      = (state == DRAIN);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_idx   = ptr;
  assign bus.out_last  = (state == DRAIN) && at_last;
  assign bus.snap_err  = snap_err_q;
  assign bus.out_data  = (state == DRAIN) ? post_proc(shadow_p1[ptr], mode_q, shift_q) : '0;
endmodule

// File: tb/tb_pu_array.sv
// Self-checking bench for pu_array: directed test-plan cases plus randomized
// accumulate/drain traffic against a plain-integer reference model.
module tb_pu_array;
  localparam int LANES  = 4;
  localparam int XW     = 25;
  localparam int WW     = 18;
  localparam int ACCW   = 32;
  localparam int PSHIFT = 0;
  localparam int OUTW   = 16;
  localparam int SHW    = 5;
  localparam int IDXW   = $clog2(LANES);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pu_array_if #(.LANES(LANES), .XW(XW), .WW(WW), .OUTW(OUTW), .SHW(SHW)) bus ();

  pu_array #(.LANES(LANES), .XW(XW), .WW(WW), .ACCW(ACCW), .PSHIFT(PSHIFT),
             .OUTW(OUTW), .SHW(SHW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int macc   [LANES];
  int wv     [LANES];
  int exp_sh [LANES];
  int exp_mode, exp_shift;

  // Reference post-processing written straight from the mode rules.
  function automatic logic [OUTW-1:0] ref_post(input int sh, input int m, input int s);
    longint v, mx, mn;
    v  = sh;
    mx = (64'sd1 <<< (OUTW - 1)) - 1;
    mn = -mx - 1;
    if (m < 2) begin
      if (m == 0) v = v >>> s;
      if (v <= 0)      v = 0;
      else if (v > mx) v = mx;
    end else begin
      if (v > mx)      v = mx;
      else if (v < mn) v = mn;
    end
    return OUTW'(v);
  endfunction

  function automatic int rnd(input int span);
    return int'($urandom_range(2 * span)) - span;
  endfunction

  task automatic set_w(input int a, input int b, input int c, input int d);
    wv[0] = a; wv[1] = b; wv[2] = c; wv[3] = d;
    for (int k = 0; k < LANES; k++) bus.w_in[WW*k +: WW] = wv[k][WW-1:0];
  endtask

  task automatic rand_xw();
    bus.x_in = XW'(rnd(2000));
    set_w(rnd(100), rnd(100), rnd(100), rnd(100));
  endtask

  // One clock: the model takes the inputs present before the edge.
  task automatic cycle();
    logic   c, e;
    longint x, p;
    c = bus.acc_clear;
    e = bus.acc_en;
    x = longint'(bus.x_in);
    @(posedge clk);
    for (int k = 0; k < LANES; k++) begin
      p = (x * longint'(wv[k])) >>> PSHIFT;
      if (c && e)  macc[k] = int'(p);
      else if (c)  macc[k] = 0;
      else if (e)  macc[k] = macc[k] + int'(p);
    end
    #1;
  endtask

  task automatic do_snap(input int m, input int s);
    bus.snap  = 1'b1;
    bus.mode  = 2'(m);
    bus.shift = SHW'(s);
    exp_sh    = macc;
    exp_mode  = m;
    exp_shift = s;
    cycle();
    bus.snap  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0)    begin errors++; $display("FAIL reset out_data got %h exp 0", bus.out_data); end
    checks++; if (bus.out_idx !== '0)     begin errors++; $display("FAIL reset out_idx got %0d exp 0", bus.out_idx); end
    checks++; if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL reset out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.snap_err !== 1'b0)  begin errors++; $display("FAIL reset snap_err got %b exp 0", bus.snap_err); end
    rst = 1'b0;
    for (int k = 0; k < LANES; k++) macc[k] = 0;
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post-reset out_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_mode1_basic();
    logic [OUTW-1:0] tab [LANES];
    tab = '{16'd12, 16'd0, 16'd42, 16'd0};
    bus.acc_clear = 1'b1; cycle(); bus.acc_clear = 1'b0;
    set_w(2, -5, 7, 0); bus.x_in = XW'(3);
    bus.acc_en = 1'b1; cycle(); cycle(); bus.acc_en = 1'b0;
    do_snap(1, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL m1 valid lane %0d got %b", k, bus.out_valid); end
      checks++; if (bus.out_idx !== IDXW'(k)) begin errors++; $display("FAIL m1 idx got %0d exp %0d", bus.out_idx, k); end
      checks++; if (bus.out_data !== tab[k]) begin errors++; $display("FAIL m1 data lane %0d got %0d exp %0d", k, bus.out_data, tab[k]); end
      checks++; if (bus.out_last !== (k == LANES - 1)) begin errors++; $display("FAIL m1 last lane %0d got %b", k, bus.out_last); end
      cycle();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL m1 busy after drain got %b exp 0", bus.busy); end
  endtask

  task automatic test_mode0_shift();
    logic [OUTW-1:0] tab [LANES];
    tab = '{16'd1171, 16'd0, 16'd19, 16'd0};
    set_w(300, -300, 5, 0); bus.x_in = XW'(1000);
    bus.acc_clear = 1'b1; bus.acc_en = 1'b1; cycle();
    bus.acc_clear = 1'b0; bus.acc_en = 1'b0;
    do_snap(0, 8);
    bus.out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      checks++; if (bus.out_data !== tab[k]) begin errors++; $display("FAIL m0 data lane %0d got %0d exp %0d", k, bus.out_data, tab[k]); end
      cycle();
    end
  endtask

  task automatic test_mode2_clamp();
    logic [OUTW-1:0] tab [LANES];
    tab = '{16'h7FFF, 16'h8000, 16'hFFFB, 16'h3039};
    set_w(40000, -40000, -5, 12345); bus.x_in = XW'(1);
    bus.acc_clear = 1'b1; bus.acc_en = 1'b1; cycle();
    bus.acc_clear = 1'b0; bus.acc_en = 1'b0;
    for (int m = 2; m < 4; m++) begin
      do_snap(m, 3);
      bus.out_ready = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        checks++; if (bus.out_data !== tab[k]) begin errors++; $display("FAIL m%0d data lane %0d got %h exp %h", m, k, bus.out_data, tab[k]); end
        cycle();
      end
    end
  endtask

  task automatic test_random_stall();
    int  ptr;
    bit  done, rdy;
    bus.acc_clear = 1'b1; bus.acc_en = 1'b1; rand_xw(); cycle(); bus.acc_clear = 1'b0;
    for (int it = 0; it < 6; it++) begin
      repeat (2) begin rand_xw(); cycle(); end
      bus.acc_en = 1'($urandom_range(1));
      do_snap(int'($urandom_range(3)), int'($urandom_range(11)));
      ptr = 0; done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rnd valid it%0d got %b", it, bus.out_valid); end
        checks++; if (bus.out_idx !== IDXW'(ptr)) begin errors++; $display("FAIL rnd idx it%0d got %0d exp %0d", it, bus.out_idx, ptr); end
        checks++; if (bus.out_data !== ref_post(exp_sh[ptr], exp_mode, exp_shift))
          begin errors++; $display("FAIL rnd data it%0d lane %0d got %h exp %h", it, ptr, bus.out_data, ref_post(exp_sh[ptr], exp_mode, exp_shift)); end
        checks++; if (bus.out_last !== (ptr == LANES - 1)) begin errors++; $display("FAIL rnd last it%0d got %b", it, bus.out_last); end
        rdy = 1'($urandom_range(1));
        bus.out_ready = rdy;
        bus.acc_en = 1'($urandom_range(1));
        rand_xw();
        cycle();
        if (rdy) begin
          if (ptr == LANES - 1) done = 1'b1;
          else ptr++;
        end
      end
      if (!done) begin checks++; errors++; $display("FAIL rnd drain timeout it%0d got idx %0d exp done", it, bus.out_idx); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd busy after drain got %b exp 0", bus.busy); end
    end
    bus.acc_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.acc_clear = 1'b1; bus.acc_en = 1'b1; rand_xw(); cycle();
    bus.acc_clear = 1'b0; bus.acc_en = 1'b0;
    do_snap(2, 0);
    bus.out_ready = 1'b1;
    bus.snap = 1'b1; bus.mode = 2'd0; cycle(); bus.snap = 1'b0;
    checks++; if (bus.snap_err !== 1'b1) begin errors++; $display("FAIL b2b snap_err got %b exp 1", bus.snap_err); end
    checks++; if (bus.out_idx !== IDXW'(1)) begin errors++; $display("FAIL b2b idx after reject got %0d exp 1", bus.out_idx); end
    checks++; if (bus.out_data !== ref_post(exp_sh[1], 2, 0)) begin errors++; $display("FAIL b2b data lane1 got %h exp %h", bus.out_data, ref_post(exp_sh[1], 2, 0)); end
    cycle();
    checks++; if (bus.snap_err !== 1'b0) begin errors++; $display("FAIL b2b snap_err pulse got %b exp 0", bus.snap_err); end
    cycle();
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL b2b last got %b exp 1", bus.out_last); end
    // final handshake with a new snapshot while the accumulators also update
    bus.acc_en = 1'b1; rand_xw();
    do_snap(1, 0);
    bus.acc_en = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b busy got %b exp 1", bus.busy); end
    checks++; if (bus.snap_err !== 1'b0) begin errors++; $display("FAIL b2b snap_err on accept got %b exp 0", bus.snap_err); end
    for (int k = 0; k < LANES; k++) begin
      checks++; if (bus.out_idx !== IDXW'(k)) begin errors++; $display("FAIL b2b idx2 got %0d exp %0d", bus.out_idx, k); end
      checks++; if (bus.out_data !== ref_post(exp_sh[k], 1, 0)) begin errors++; $display("FAIL b2b data2 lane %0d got %h exp %h", k, bus.out_data, ref_post(exp_sh[k], 1, 0)); end
      cycle();
    end
    do_snap(2, 0);
    checks++; if (bus.out_data !== ref_post(exp_sh[0], 2, 0)) begin errors++; $display("FAIL b2b data3 lane0 got %h exp %h", bus.out_data, ref_post(exp_sh[0], 2, 0)); end
    repeat (LANES) cycle();
  endtask

  task automatic test_reset_mid_drain();
    bus.acc_clear = 1'b1; bus.acc_en = 1'b1; rand_xw(); cycle();
    bus.acc_clear = 1'b0; bus.acc_en = 1'b0;
    do_snap(2, 0);
    bus.out_ready = 1'b1;
    cycle(); cycle();
    checks++; if (bus.out_idx !== IDXW'(2)) begin errors++; $display("FAIL rmid idx before reset got %0d exp 2", bus.out_idx); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rmid busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_data !== '0)    begin errors++; $display("FAIL rmid data got %h exp 0", bus.out_data); end
    checks++; if (bus.out_idx !== '0)     begin errors++; $display("FAIL rmid idx got %0d exp 0", bus.out_idx); end
    checks++; if (bus.out_last !== 1'b0)  begin errors++; $display("FAIL rmid last got %b exp 0", bus.out_last); end
    for (int k = 0; k < LANES; k++) macc[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      cycle();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid valid after release got %b exp 0", bus.out_valid); end
    end
    bus.acc_en = 1'b1; set_w(9, -9, 1000, -1000); bus.x_in = XW'(50); cycle(); bus.acc_en = 1'b0;
    do_snap(2, 0);
    for (int k = 0; k < LANES; k++) begin
      checks++; if (bus.out_data !== ref_post(exp_sh[k], 2, 0)) begin errors++; $display("FAIL rmid data lane %0d got %h exp %h", k, bus.out_data, ref_post(exp_sh[k], 2, 0)); end
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.acc_clear = 1'b0;
    bus.acc_en    = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus.snap      = 1'b0;
    bus.mode      = '0;
    bus.shift     = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) begin macc[k] = 0; wv[k] = 0; exp_sh[k] = 0; end
    test_reset();
    test_mode1_basic();
    test_mode0_shift();
    test_mode2_clamp();
    test_random_stall();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
